// File: rtl/spiking_pkg.sv
// Shared definitions for the spiking LIF layer: width defaults, FSM encoding
// and the membrane saturation helper.
package spiking_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_VMEM_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } lif_state_e;

  // Clamp a wide signed sum into the signed range of 'width' bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] sum,
                                                  input int unsigned       width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane register, leak, integrate,
// saturate, threshold with soft reset, and a registered spike bit.
module lif_neuron
  import spiking_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int VMEM_WIDTH = DEF_VMEM_WIDTH,
  parameter int THRESHOLD  = 64,
  parameter int LEAK_SHIFT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] current,
  input  logic                         update_en,
  input  logic                         clear,
  output logic                         spike
);

  localparam int SW = VMEM_WIDTH + 1;
  localparam logic signed [VMEM_WIDTH-1:0] THR = VMEM_WIDTH'(THRESHOLD);

  logic signed [VMEM_WIDTH-1:0] vmem_q, vmem_d;
  logic signed [VMEM_WIDTH-1:0] leak;
  logic signed [VMEM_WIDTH-1:0] sat;
  logic signed [VMEM_WIDTH-1:0] vmem_next;
  logic signed [SW-1:0]         sum;
  logic                         fire;
  logic                         spike_q, spike_d;

  // One extra bit of headroom holds vmem - leak + current without wrapping.
  always_comb begin
    leak      = vmem_q >>> LEAK_SHIFT;
    sum       = SW'(vmem_q) - SW'(leak) + SW'(current);
    sat       = VMEM_WIDTH'(saturate(64'(sum), VMEM_WIDTH));
    fire      = (sat >= THR);
    vmem_next = fire ? (sat - THR) : sat;

    vmem_d  = vmem_q;
    spike_d = spike_q;
    if (update_en) begin
      spike_d = fire;
      vmem_d  = clear ? '0 : vmem_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vmem_q  <= '0;
      spike_q <= 1'b0;
    end else begin
      vmem_q  <= vmem_d;
      spike_q <= spike_d;
    end
  end

  assign spike = spike_q;

endmodule

// File: rtl/spiking_lif_layer.sv
// Layer of LIF neurons fed by the systolic array's column currents; one
// spike vector out per accepted current vector, frames of NUM_TIMESTEPS beats.
module spiking_lif_layer
  import spiking_pkg::*;
#(
  parameter int NUM_NEURONS   = 2,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int VMEM_WIDTH    = DEF_VMEM_WIDTH,
  parameter int THRESHOLD     = 64,
  parameter int LEAK_SHIFT    = 4,
  parameter int NUM_TIMESTEPS = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_NEURONS-1:0]            out_spike,
  output logic                              out_last,
  output logic [$clog2(NUM_TIMESTEPS)-1:0]  timestep
);

  localparam int TS_W = $clog2(NUM_TIMESTEPS);

  lif_state_e                        state_q;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] data_q;
  logic                              last_q;
  logic [TS_W-1:0]                   ts_q;
  logic                              in_ready_q;
  logic                              out_valid_q;
  logic                              out_last_q;
  logic                              update_en;
  logic                              frame_end;

  assign update_en = (state_q == UPDATE);
  assign frame_end = last_q || (ts_q == TS_W'(NUM_TIMESTEPS - 1));

  // Current vector is pure data; it only needs to be valid in UPDATE.
  always_ff @(posedge clk) begin
    if (in_ready_q && in_valid) begin
      data_q <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      ts_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            last_q     <= in_last;
            in_ready_q <= 1'b0;
            state_q    <= UPDATE;
          end
        end
        UPDATE: begin
          out_valid_q <= 1'b1;
          out_last_q  <= frame_end;
          ts_q        <= frame_end ? '0 : ts_q + TS_W'(1);
          state_q     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Neurons update only in UPDATE; a frame end clears vmem after the spike
  // has been taken from the pre-clear membrane.
  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_neuron
    lif_neuron #(
      .DATA_WIDTH(DATA_WIDTH),
      .VMEM_WIDTH(VMEM_WIDTH),
      .THRESHOLD (THRESHOLD),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_neuron (
      .clk      (clk),
      .rst      (rst),
      .current  (data_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .update_en(update_en),
      .clear    (frame_end),
      .spike    (out_spike[i])
    );
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign timestep  = ts_q;

endmodule

// File: tb/tb_spiking_lif_layer.sv
// Directed bench for spiking_lif_layer: default layer plus a saturation
// variant with a huge threshold and tiny leak.
module tb_spiking_lif_layer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data  = '0;
  logic        in_last  = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_spike;
  logic        out_last;
  logic [2:0]  timestep;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [31:0] s_in_data  = '0;
  logic        s_in_last  = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;
  logic [1:0]  s_out_spike;
  logic        s_out_last;
  logic [4:0]  s_timestep;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] r_spk;
  logic       r_last;
  int         r_ts;

  always #5 clk = ~clk;

  spiking_lif_layer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_spike(out_spike),
    .out_last (out_last),
    .timestep (timestep)
  );

  spiking_lif_layer #(
    .THRESHOLD    (524287),
    .LEAK_SHIFT   (15),
    .NUM_TIMESTEPS(32)
  ) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_data  (s_in_data),
    .in_last  (s_in_last),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_spike(s_out_spike),
    .out_last (s_out_last),
    .timestep (s_timestep)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_in_ready();
    int cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_out_valid();
    int cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic push(input logic signed [15:0] c0, input logic signed [15:0] c1,
                      input logic last);
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = {c1, c0};
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Full beat with out_ready high: capture spikes, last and timestep.
  task automatic send(input logic signed [15:0] c0, input logic signed [15:0] c1,
                      input logic last);
    push(c0, c1, last);
    wait_out_valid();
    r_spk  = out_spike;
    r_last = out_last;
    r_ts   = int'(timestep);
    @(posedge clk); #1;
  endtask

  logic [1:0] exp_spk1 [8] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};

  initial begin
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_spike", out_spike, 0);
    check("rst_out_last",  out_last,  0);
    check("rst_timestep",  timestep,  0);
    check("rst_vmem0", dut.g_neuron[0].u_neuron.vmem_q, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Constant currents 14 / 23 for one full frame.
    for (int i = 0; i < 8; i++) begin
      send(16'sd14, 16'sd23, 1'b0);
      check($sformatf("t1_spk%0d", i), r_spk, exp_spk1[i]);
      check($sformatf("t1_last%0d", i), r_last, (i == 7) ? 1 : 0);
      check($sformatf("t1_ts%0d", i), r_ts, (i + 1) % 8);
      if (i == 2) check("t1_vmem1_b2", dut.g_neuron[1].u_neuron.vmem_q, 2);
      if (i == 4) check("t1_vmem0_b4", dut.g_neuron[0].u_neuron.vmem_q, 0);
    end

    // Negative current leaks toward zero, never fires, clears at frame end.
    for (int i = 0; i < 8; i++) begin
      send(-16'sd21, 16'sd0, 1'b0);
      check($sformatf("t2_spk%0d", i), r_spk, 0);
      if (i == 0) check("t2_vmem_b0", dut.g_neuron[0].u_neuron.vmem_q, -21);
      if (i == 1) check("t2_vmem_b1", dut.g_neuron[0].u_neuron.vmem_q, -40);
      if (i == 2) check("t2_vmem_b2", dut.g_neuron[0].u_neuron.vmem_q, -58);
    end
    check("t2_last",  r_last, 1);
    check("t2_clear", dut.g_neuron[0].u_neuron.vmem_q, 0);
    check("t2_ts",    r_ts, 0);

    // Early frame end via in_last on the third beat.
    for (int i = 0; i < 3; i++) begin
      send(16'sd14, 16'sd0, (i == 2) ? 1'b1 : 1'b0);
      check($sformatf("t3_last%0d", i), r_last, (i == 2) ? 1 : 0);
      check($sformatf("t3_spk%0d", i), r_spk, 0);
    end
    check("t3_ts_wrap", r_ts, 0);
    check("t3_clear", dut.g_neuron[0].u_neuron.vmem_q, 0);
    send(16'sd14, 16'sd0, 1'b0);
    check("t3_vmem_after", dut.g_neuron[0].u_neuron.vmem_q, 14);
    check("t3_ts_after", r_ts, 1);

    // Backpressure: 14 + 100 = 114 fires neuron0, vmem 50.
    out_ready = 1'b0;
    push(16'sd100, 16'sd0, 1'b0);
    wait_out_valid();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid%0d", c), out_valid, 1);
      check($sformatf("bp_spk%0d", c), out_spike, 1);
      check($sformatf("bp_last%0d", c), out_last, 0);
      check($sformatf("bp_ready%0d", c), in_ready, 0);
      @(posedge clk); #1;
    end
    check("bp_vmem", dut.g_neuron[0].u_neuron.vmem_q, 50);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_xfer_valid", out_valid, 0);
    check("bp_xfer_ready", in_ready, 1);
    check("bp_ts", timestep, 2);
    @(posedge clk); #1;
    check("bp_single_xfer", out_valid, 0);

    // Asynchronous reset while a spike vector is pending.
    out_ready = 1'b0;
    push(16'sd100, 16'sd0, 1'b0);
    wait_out_valid();
    check("rm_pending", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rm_out_valid", out_valid, 0);
    check("rm_out_spike", out_spike, 0);
    check("rm_timestep", timestep, 0);
    check("rm_vmem0", dut.g_neuron[0].u_neuron.vmem_q, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rm_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Saturation: 32767 per beat, leak shift 15, threshold at positive rail.
    for (int b = 0; b < 17; b++) begin
      int cnt = 0;
      while (!s_in_ready && cnt < 20) begin
        @(posedge clk); #1; cnt++;
      end
      if (!s_in_ready) check("sat_in_ready_timeout", 0, 1);
      s_in_valid = 1'b1;
      s_in_data  = {16'sd0, 16'sd32767};
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      cnt = 0;
      while (!s_out_valid && cnt < 20) begin
        @(posedge clk); #1; cnt++;
      end
      if (!s_out_valid) check("sat_out_valid_timeout", 0, 1);
      check($sformatf("sat_spk%0d", b), s_out_spike, (b == 16) ? 1 : 0);
      if (b == 2)  check("sat_vmem_b2",  dut_sat.g_neuron[0].u_neuron.vmem_q, 98300);
      if (b == 15) check("sat_vmem_b15", dut_sat.g_neuron[0].u_neuron.vmem_q, 524167);
      if (b == 16) check("sat_vmem_b16", dut_sat.g_neuron[0].u_neuron.vmem_q, 0);
      @(posedge clk); #1;
    end
    check("sat_ts", s_timestep, 17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
